// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared state encodings, word size and address-split width
//               helpers for the instruction cache fill controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_STATE_IDLE   = 2'd0;
    localparam state_t c_STATE_FILL   = 2'd1;
    localparam state_t c_STATE_COMMIT = 2'd2;

    localparam int c_WORD_BYTES = 4;
    localparam int c_BYTE_OFF_W = $clog2(c_WORD_BYTES);

    function automatic int offsetWidth(input int lineWords);
        return $clog2(lineWords);
    endfunction

    function automatic int indexWidth(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagWidth(input int addrW, input int sets, input int lineWords);
        return addrW - indexWidth(sets) - offsetWidth(lineWords) - c_BYTE_OFF_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_tag_ram.sv
// ============================================================================
// Module      : icache_tag_ram
// Description : Tag storage plus per-set valid bits with a flush-all port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_tag_ram
    import icache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 56
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic [IDX_W-1:0] i_rdIndex,
    output logic [TAG_W-1:0] o_rdTag,
    output logic             o_rdValid,
    input  logic             i_wrEn,
    input  logic [IDX_W-1:0] i_wrIndex,
    input  logic [TAG_W-1:0] i_wrTag,
    input  logic             i_setValid
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag [SETS];

    // Flush outranks a same-cycle commit so an aborted line never turns valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_wrEn) begin
            r_valid[i_wrIndex] <= i_setValid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_tag[i_wrIndex] <= i_wrTag;
        end
    end

    assign o_rdTag   = r_tag[i_rdIndex];
    assign o_rdValid = (r_valid[i_rdIndex] === 1'b1);

endmodule

`default_nettype wire

// File: rtl/icache_fill_ctrl.sv
// ============================================================================
// Module      : icache_fill_ctrl
// Description : Direct-mapped instruction cache with line refill FSM.
//               Define ICACHE_STATS_EN to add saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [31:0]       instruction,
    output logic              hit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              busy
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int c_OFF_W = offsetWidth(LINE_WORDS);
    localparam int c_IDX_W = indexWidth(SETS);
    localparam int c_TAG_W = tagWidth(ADDR_W, SETS, LINE_WORDS);

    state_t               r_state;
    logic [c_TAG_W-1:0]   r_missTag;
    logic [c_IDX_W-1:0]   r_missIndex;
    logic [c_OFF_W-1:0]   r_wordCnt;
    logic                 r_abort;
    logic [31:0]          r_data [SETS*LINE_WORDS];

    logic [c_OFF_W-1:0]   w_offset;
    logic [c_IDX_W-1:0]   w_index;
    logic [c_TAG_W-1:0]   w_tag;
    logic [c_TAG_W-1:0]   w_storedTag;
    logic                 w_storedValid;
    logic                 w_hit;
    logic                 w_lastBeat;
    logic                 w_unusedPcBits;

    assign w_offset       = pc[c_BYTE_OFF_W +: c_OFF_W];
    assign w_index        = pc[c_BYTE_OFF_W + c_OFF_W +: c_IDX_W];
    assign w_tag          = pc[ADDR_W-1 -: c_TAG_W];
    assign w_unusedPcBits = ^pc[c_BYTE_OFF_W-1:0];

    icache_tag_ram #(
        .SETS  (SETS),
        .IDX_W (c_IDX_W),
        .TAG_W (c_TAG_W)
    ) u_tagRam (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (flush),
        .i_rdIndex  (w_index),
        .o_rdTag    (w_storedTag),
        .o_rdValid  (w_storedValid),
        .i_wrEn     (r_state == c_STATE_COMMIT),
        .i_wrIndex  (r_missIndex),
        .i_wrTag    (r_missTag),
        .i_setValid (!r_abort)
    );

    assign w_hit      = (r_state == c_STATE_IDLE) && w_storedValid && (w_storedTag == w_tag);
    assign w_lastBeat = (r_wordCnt == c_OFF_W'(LINE_WORDS - 1));

    // A flush in COMMIT needs no abort: the tag RAM flush already wins that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_STATE_IDLE;
            r_wordCnt <= '0;
            r_abort   <= 1'b0;
        end else begin
            case (r_state)
                c_STATE_IDLE: begin
                    if (!w_hit) begin
                        r_state     <= c_STATE_FILL;
                        r_missTag   <= w_tag;
                        r_missIndex <= w_index;
                        r_wordCnt   <= '0;
                    end
                end
                c_STATE_FILL: begin
                    if (flush) begin
                        r_abort <= 1'b1;
                    end
                    if (mem_ready) begin
                        r_wordCnt <= r_wordCnt + 1'b1;
                        if (w_lastBeat) begin
                            r_state <= c_STATE_COMMIT;
                        end
                    end
                end
                c_STATE_COMMIT: begin
                    r_state <= c_STATE_IDLE;
                    r_abort <= 1'b0;
                end
                default: begin
                    r_state <= c_STATE_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_STATE_FILL) && mem_ready) begin
            r_data[{r_missIndex, r_wordCnt}] <= mem_rdata;
        end
    end

    assign hit         = w_hit;
    assign instruction = w_hit ? r_data[{w_index, w_offset}] : 32'h0;
    assign mem_req     = (r_state == c_STATE_FILL);
    assign mem_addr    = (r_state == c_STATE_FILL)
                       ? {r_missTag, r_missIndex, r_wordCnt, {c_BYTE_OFF_W{1'b0}}}
                       : '0;
    assign busy        = (r_state == c_STATE_FILL) || (r_state == c_STATE_COMMIT);

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hitCount;
    logic [31:0] r_missCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else begin
            if (w_hit && (r_hitCount != 32'hFFFF_FFFF)) begin
                r_hitCount <= r_hitCount + 32'd1;
            end
            if ((r_state == c_STATE_IDLE) && !w_hit && (r_missCount != 32'hFFFF_FFFF)) begin
                r_missCount <= r_missCount + 32'd1;
            end
        end
    end

    assign hit_count  = r_hitCount;
    assign miss_count = r_missCount;
`endif

endmodule

`default_nettype wire
